cvxif_ma_responder: RTL and testbench

Coprocessor-side (responder) end of the CV-X-IF link that CVA6 drives when `CvxifEn` is set. It decodes each offered instruction, accepts custom-0 matrix-accelerator instructions and rejects everything else. It keeps accepted instructions in a small in-order queue until CVA6 commits or kills them, then dispatches committed ones to the matrix-accelerator backend. Exactly one result per accepted, non-killed instruction is returned to CVA6.

---
 rtl/cvxif_ma_responder.sv | 209 ++++++++++++++++++++
 tb/tb_cvxif_ma_responder.sv | 383 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cvxif_ma_responder.sv
// CV-X-IF responder for custom-0 matrix instructions: decode/accept, in-order pending queue, commit-gated dispatch.
// Latency: issue response combinational; cmd_valid_o 1 cycle after commit of head; result 1 cycle after cmd/rsp handshake.
// Backpressure: issue_ready_o drops when queue full or operands missing; cmd_*/result_* held stable until ready.
module cvxif_ma_responder #(
    parameter int          XLEN    = 32,
    parameter int          IdWidth = 3,
    parameter int          Depth   = 4,
    parameter logic [6:0]  Opcode  = 7'h0B
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               issue_valid_i,
    output logic               issue_ready_o,
    input  logic [31:0]        issue_instr_i,
    input  logic [IdWidth-1:0] issue_id_i,
    input  logic [XLEN-1:0]    issue_rs1_i,
    input  logic [XLEN-1:0]    issue_rs2_i,
    input  logic [1:0]         issue_rs_valid_i,
    output logic               issue_accept_o,
    output logic               issue_writeback_o,
    output logic [1:0]         issue_register_read_o,
    input  logic               commit_valid_i,
    input  logic [IdWidth-1:0] commit_id_i,
    input  logic               commit_kill_i,
    output logic               result_valid_o,
    input  logic               result_ready_i,
    output logic [IdWidth-1:0] result_id_o,
    output logic [XLEN-1:0]    result_data_o,
    output logic [4:0]         result_rd_o,
    output logic               result_we_o,
    output logic               cmd_valid_o,
    input  logic               cmd_ready_i,
    output logic [9:0]         cmd_funct_o,
    output logic [XLEN-1:0]    cmd_rs1_o,
    output logic [XLEN-1:0]    cmd_rs2_o,
    output logic [IdWidth-1:0] cmd_id_o,
    input  logic               rsp_valid_i,
    input  logic [XLEN-1:0]    rsp_data_i,
    output logic               rsp_ready_o
);
    localparam int PtrW = $clog2(Depth);

    typedef struct packed {
        logic [IdWidth-1:0] id;
        logic [9:0]         funct;
        logic [XLEN-1:0]    rs1;
        logic [XLEN-1:0]    rs2;
        logic [4:0]         rd;
        logic               wb;
    } ent_t;

    typedef enum logic [1:0] {S_IDLE, S_CMD, S_RSP, S_RES} state_t;

    state_t            state;
    ent_t              q_dat [Depth];
    logic [Depth-1:0]  q_com;
    logic [Depth-1:0]  q_kil;
    logic [PtrW:0]     wptr;
    logic [PtrW:0]     rptr;
    logic [PtrW:0]     count;
    logic [PtrW-1:0]   slot_off [Depth];
    logic [Depth-1:0]  id_hit;

    logic [6:0]        instr_opc;
    logic [2:0]        instr_f3;
    logic [4:0]        instr_rd;
    logic              match;
    logic              full;
    logic              empty;
    logic              push;
    logic              push_hit;
    logic              head_com;
    logic              head_kil;
    logic [PtrW-1:0]   head_idx;
    ent_t              head;
    ent_t              new_ent;
    logic              instr_unused;

    assign instr_opc    = issue_instr_i[6:0];
    assign instr_f3     = issue_instr_i[14:12];
    assign instr_rd     = issue_instr_i[11:7];
    assign instr_unused = ^issue_instr_i[24:15];

    assign match                 = (instr_opc == Opcode) && (instr_f3 != 3'b111);
    assign issue_accept_o        = issue_valid_i & match;
    assign issue_writeback_o     = issue_accept_o & instr_f3[2] & (instr_rd != 5'd0);
    assign issue_register_read_o = {issue_accept_o, issue_accept_o};

    assign empty = (wptr == rptr);
    assign full  = (wptr[PtrW] != rptr[PtrW]) && (wptr[PtrW-1:0] == rptr[PtrW-1:0]);
    assign count = wptr - rptr;

    // Non-matching instructions are always rejected immediately, even with a full queue.
    assign issue_ready_o = match ? (!full && (issue_rs_valid_i == 2'b11)) : 1'b1;
    assign push          = issue_accept_o & issue_ready_o;
    assign push_hit      = commit_valid_i && (commit_id_i == issue_id_i);

    assign new_ent = '{id:    issue_id_i,
                       funct: {issue_instr_i[31:25], instr_f3},
                       rs1:   issue_rs1_i,
                       rs2:   issue_rs2_i,
                       rd:    instr_rd,
                       wb:    instr_f3[2] & (instr_rd != 5'd0)};

    always_comb begin
        for (int i = 0; i < Depth; i++) begin
            slot_off[i] = PtrW'(i) - rptr[PtrW-1:0];
            id_hit[i]   = ({1'b0, slot_off[i]} < count) && commit_valid_i
                          && (q_dat[i].id == commit_id_i);
        end
    end

    // Head decision folds in this cycle's commit so dispatch starts on the commit edge.
    assign head_idx = rptr[PtrW-1:0];
    assign head     = q_dat[head_idx];
    assign head_com = q_com[head_idx] | (id_hit[head_idx] & !commit_kill_i);
    assign head_kil = q_kil[head_idx] | (id_hit[head_idx] & commit_kill_i);

    always_ff @(posedge clk_i) begin
        if (push) begin
            q_dat[wptr[PtrW-1:0]] <= new_ent;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wptr           <= '0;
            rptr           <= '0;
            q_com          <= '0;
            q_kil          <= '0;
            state          <= S_IDLE;
            cmd_valid_o    <= 1'b0;
            cmd_funct_o    <= '0;
            cmd_rs1_o      <= '0;
            cmd_rs2_o      <= '0;
            cmd_id_o       <= '0;
            rsp_ready_o    <= 1'b0;
            result_valid_o <= 1'b0;
            result_id_o    <= '0;
            result_data_o  <= '0;
            result_rd_o    <= '0;
            result_we_o    <= 1'b0;
        end else begin
            for (int i = 0; i < Depth; i++) begin
                if (id_hit[i]) begin
                    if (commit_kill_i) q_kil[i] <= 1'b1;
                    else               q_com[i] <= 1'b1;
                end
            end
            if (push) begin
                q_com[wptr[PtrW-1:0]] <= push_hit & !commit_kill_i;
                q_kil[wptr[PtrW-1:0]] <= push_hit & commit_kill_i;
                wptr                  <= wptr + (PtrW+1)'(1);
            end

            case (state)
                S_IDLE: begin
                    if (!empty) begin
                        if (head_kil) begin
                            rptr <= rptr + (PtrW+1)'(1);
                        end else if (head_com) begin
                            state       <= S_CMD;
                            cmd_valid_o <= 1'b1;
                            cmd_funct_o <= head.funct;
                            cmd_rs1_o   <= head.rs1;
                            cmd_rs2_o   <= head.rs2;
                            cmd_id_o    <= head.id;
                        end
                    end
                end
                S_CMD: begin
                    if (cmd_ready_i) begin
                        cmd_valid_o <= 1'b0;
                        if (head.wb) begin
                            state       <= S_RSP;
                            rsp_ready_o <= 1'b1;
                        end else begin
                            state          <= S_RES;
                            result_valid_o <= 1'b1;
                            result_id_o    <= head.id;
                            result_data_o  <= '0;
                            result_rd_o    <= head.rd;
                            result_we_o    <= 1'b0;
                        end
                    end
                end
                S_RSP: begin
                    if (rsp_valid_i) begin
                        state          <= S_RES;
                        rsp_ready_o    <= 1'b0;
                        result_valid_o <= 1'b1;
                        result_id_o    <= head.id;
                        result_data_o  <= rsp_data_i;
                        result_rd_o    <= head.rd;
                        result_we_o    <= 1'b1;
                    end
                end
                S_RES: begin
                    if (result_ready_i) begin
                        state          <= S_IDLE;
                        result_valid_o <= 1'b0;
                        rptr           <= rptr + (PtrW+1)'(1);
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_cvxif_ma_responder.sv
// Bench for cvxif_ma_responder: directed scenarios plus random traffic against a queue-level reference model.
module tb_cvxif_ma_responder;
    localparam int DEPTH = 4;
    localparam int P_IDLE = 0, P_CMD = 1, P_RSP = 2, P_RES = 3;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        issue_valid, issue_ready, issue_accept, issue_writeback;
    logic [31:0] issue_instr;
    logic [2:0]  issue_id;
    logic [31:0] issue_rs1, issue_rs2;
    logic [1:0]  issue_rs_valid, issue_register_read;
    logic        commit_valid, commit_kill;
    logic [2:0]  commit_id;
    logic        result_valid, result_ready, result_we;
    logic [2:0]  result_id;
    logic [31:0] result_data;
    logic [4:0]  result_rd;
    logic        cmd_valid, cmd_ready;
    logic [9:0]  cmd_funct;
    logic [31:0] cmd_rs1, cmd_rs2;
    logic [2:0]  cmd_id;
    logic        rsp_valid, rsp_ready;
    logic [31:0] rsp_data;

    always #5 clk = ~clk;

    cvxif_ma_responder dut (
        .clk_i(clk), .rst_i(rst),
        .issue_valid_i(issue_valid), .issue_ready_o(issue_ready), .issue_instr_i(issue_instr),
        .issue_id_i(issue_id), .issue_rs1_i(issue_rs1), .issue_rs2_i(issue_rs2),
        .issue_rs_valid_i(issue_rs_valid), .issue_accept_o(issue_accept),
        .issue_writeback_o(issue_writeback), .issue_register_read_o(issue_register_read),
        .commit_valid_i(commit_valid), .commit_id_i(commit_id), .commit_kill_i(commit_kill),
        .result_valid_o(result_valid), .result_ready_i(result_ready), .result_id_o(result_id),
        .result_data_o(result_data), .result_rd_o(result_rd), .result_we_o(result_we),
        .cmd_valid_o(cmd_valid), .cmd_ready_i(cmd_ready), .cmd_funct_o(cmd_funct),
        .cmd_rs1_o(cmd_rs1), .cmd_rs2_o(cmd_rs2), .cmd_id_o(cmd_id),
        .rsp_valid_i(rsp_valid), .rsp_data_i(rsp_data), .rsp_ready_o(rsp_ready)
    );

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    typedef struct {
        logic [2:0]  id;
        logic [9:0]  funct;
        logic [31:0] rs1;
        logic [31:0] rs2;
        logic [4:0]  rd;
        bit          wb;
        bit          com;
        bit          kil;
    } ent_t;

    ent_t        mq[$];
    int          phase  = P_IDLE;
    logic [31:0] m_data = '0;
    bit          chk_en = 1'b0;
    logic [2:0]  cmd_log[$];
    logic [2:0]  res_log[$];
    int          res_cnt = 0;

    // Reference model: compare outputs, then advance the queue as the clock edge would.
    always @(negedge clk) begin
        logic [6:0] op;
        logic [2:0] f3;
        logic [4:0] rdf;
        bit         match, acc, exp_rdy, push;
        ent_t       e;
        op      = issue_instr[6:0];
        f3      = issue_instr[14:12];
        rdf     = issue_instr[11:7];
        match   = (op == 7'h0B) && (f3 != 3'd7);
        acc     = issue_valid && match;
        exp_rdy = match ? (mq.size() < DEPTH && issue_rs_valid == 2'b11) : 1'b1;
        push    = acc && exp_rdy;
        if (chk_en && !rst) begin
            chk("m_issue_ready", 32'(issue_ready), 32'(exp_rdy));
            chk("m_issue_accept", 32'(issue_accept), 32'(acc));
            chk("m_issue_wb", 32'(issue_writeback), 32'(acc && f3[2] && rdf != 5'd0));
            chk("m_issue_rr", 32'(issue_register_read), 32'({acc, acc}));
            chk("m_cmd_valid", 32'(cmd_valid), 32'(phase == P_CMD));
            chk("m_rsp_ready", 32'(rsp_ready), 32'(phase == P_RSP));
            chk("m_result_valid", 32'(result_valid), 32'(phase == P_RES));
            if (phase == P_CMD && mq.size() > 0) begin
                chk("m_cmd_funct", 32'(cmd_funct), 32'(mq[0].funct));
                chk("m_cmd_rs1", cmd_rs1, mq[0].rs1);
                chk("m_cmd_rs2", cmd_rs2, mq[0].rs2);
                chk("m_cmd_id", 32'(cmd_id), 32'(mq[0].id));
            end
            if (phase == P_RES && mq.size() > 0) begin
                chk("m_res_id", 32'(result_id), 32'(mq[0].id));
                chk("m_res_rd", 32'(result_rd), 32'(mq[0].rd));
                chk("m_res_we", 32'(result_we), 32'(mq[0].wb));
                chk("m_res_data", result_data, m_data);
            end
            if (cmd_valid && cmd_ready) cmd_log.push_back(cmd_id);
            if (result_valid && result_ready) begin
                res_log.push_back(result_id);
                res_cnt++;
            end
        end
        if (rst) begin
            mq.delete();
            phase  = P_IDLE;
            m_data = '0;
        end else if (chk_en) begin
            if (commit_valid) begin
                for (int i = 0; i < mq.size(); i++) begin
                    if (mq[i].id == commit_id) begin
                        e = mq[i];
                        if (commit_kill) e.kil = 1'b1; else e.com = 1'b1;
                        mq[i] = e;
                    end
                end
            end
            case (phase)
                P_IDLE: if (mq.size() > 0) begin
                    if (mq[0].kil) mq.delete(0);
                    else if (mq[0].com) phase = P_CMD;
                end
                P_CMD: if (cmd_ready) begin
                    if (mq[0].wb) phase = P_RSP;
                    else begin phase = P_RES; m_data = '0; end
                end
                P_RSP: if (rsp_valid) begin phase = P_RES; m_data = rsp_data; end
                default: if (result_ready) begin mq.delete(0); phase = P_IDLE; end
            endcase
            if (push) begin
                e.id    = issue_id;
                e.funct = {issue_instr[31:25], f3};
                e.rs1   = issue_rs1;
                e.rs2   = issue_rs2;
                e.rd    = rdf;
                e.wb    = f3[2] && rdf != 5'd0;
                e.com   = commit_valid && !commit_kill && commit_id == issue_id;
                e.kil   = commit_valid && commit_kill && commit_id == issue_id;
                mq.push_back(e);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_in();
        issue_valid = 0; issue_instr = '0; issue_id = '0; issue_rs1 = '0; issue_rs2 = '0;
        issue_rs_valid = 2'b00; commit_valid = 0; commit_id = '0; commit_kill = 0;
        cmd_ready = 0; result_ready = 0; rsp_valid = 0; rsp_data = '0;
    endtask

    function automatic logic [31:0] mkins(input logic [6:0] f7, input logic [2:0] f3, input logic [4:0] rd);
        return {f7, 10'd0, f3, rd, 7'h0B};
    endfunction

    initial begin
        int seen;
        bit found;
        logic [6:0] f7;
        logic [2:0] f3r;
        logic [4:0] rdr;
        // reset state
        idle_in();
        rst = 1'b1;
        repeat (3) tick();
        rst = 1'b0;
        chk_en = 1'b1;
        @(negedge clk);
        chk("rst_issue_ready", 32'(issue_ready), 32'd1);
        chk("rst_cmd_valid", 32'(cmd_valid), 32'd0);
        chk("rst_result_valid", 32'(result_valid), 32'd0);
        chk("rst_rsp_ready", 32'(rsp_ready), 32'd0);
        chk("rst_result_data", result_data, 32'd0);

        // reject addi
        tick();
        issue_valid = 1; issue_instr = 32'h00200093; issue_id = 3'd2; issue_rs_valid = 2'b11;
        @(negedge clk);
        chk("rej_ready", 32'(issue_ready), 32'd1);
        chk("rej_accept", 32'(issue_accept), 32'd0);
        tick();
        idle_in();
        seen = 0;
        repeat (5) begin
            @(negedge clk);
            if (result_valid) seen++;
            tick();
        end
        chk("rej_no_result", 32'(seen), 32'd0);

        // no-writeback command
        issue_valid = 1; issue_instr = mkins(7'h00, 3'd1, 5'd0); issue_id = 3'd1;
        issue_rs1 = 32'h10; issue_rs2 = 32'h20; issue_rs_valid = 2'b11;
        cmd_ready = 1; result_ready = 1;
        @(negedge clk);
        chk("nwb_accept", 32'(issue_accept), 32'd1);
        chk("nwb_wb", 32'(issue_writeback), 32'd0);
        tick();
        issue_valid = 0; commit_valid = 1; commit_id = 3'd1; commit_kill = 0;
        tick();
        commit_valid = 0;
        @(negedge clk);
        chk("nwb_cmd_valid", 32'(cmd_valid), 32'd1);
        chk("nwb_cmd_funct", 32'(cmd_funct), 32'h001);
        chk("nwb_cmd_rs1", cmd_rs1, 32'h10);
        chk("nwb_cmd_rs2", cmd_rs2, 32'h20);
        tick();
        @(negedge clk);
        chk("nwb_res_valid", 32'(result_valid), 32'd1);
        chk("nwb_res_id", 32'(result_id), 32'd1);
        chk("nwb_res_we", 32'(result_we), 32'd0);
        chk("nwb_res_data", result_data, 32'd0);
        tick();

        // writeback command, backend response three cycles into RSP, result held
        issue_valid = 1; issue_instr = mkins(7'h00, 3'd4, 5'd5); issue_id = 3'd3;
        issue_rs1 = 32'hA; issue_rs2 = 32'hB; cmd_ready = 1; result_ready = 0;
        @(negedge clk);
        chk("wb_writeback", 32'(issue_writeback), 32'd1);
        tick();
        issue_valid = 0; commit_valid = 1; commit_id = 3'd3;
        tick();
        commit_valid = 0;
        @(negedge clk);
        chk("wb_cmd_funct", 32'(cmd_funct), 32'h004);
        tick();
        @(negedge clk);
        chk("wb_rsp_ready", 32'(rsp_ready), 32'd1);
        tick();
        tick();
        rsp_valid = 1; rsp_data = 32'hDEADBEEF;
        tick();
        rsp_valid = 0; rsp_data = '0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("wb_res_valid", 32'(result_valid), 32'd1);
            chk("wb_res_id", 32'(result_id), 32'd3);
            chk("wb_res_rd", 32'(result_rd), 32'd5);
            chk("wb_res_we", 32'(result_we), 32'd1);
            chk("wb_res_data", result_data, 32'hDEADBEEF);
            tick();
        end
        result_ready = 1;
        tick();
        @(negedge clk);
        chk("wb_res_done", 32'(result_valid), 32'd0);
        tick();

        // kill the middle of three
        cmd_log.delete();
        res_log.delete();
        for (int k = 0; k < 3; k++) begin
            issue_valid = 1; issue_instr = mkins(7'h01, 3'd2, 5'd1); issue_id = 3'(k);
            issue_rs1 = 32'(k + 100); issue_rs2 = 32'(k);
            tick();
        end
        issue_valid = 0;
        commit_valid = 1; commit_id = 3'd1; commit_kill = 1;
        tick();
        commit_id = 3'd0; commit_kill = 0;
        tick();
        commit_id = 3'd2;
        tick();
        commit_valid = 0;
        repeat (20) tick();
        chk("kill_cmd_cnt", 32'(cmd_log.size()), 32'd2);
        chk("kill_res_cnt", 32'(res_log.size()), 32'd2);
        chk("kill_res0", res_log.size() > 0 ? 32'(res_log[0]) : 32'hFFFF, 32'd0);
        chk("kill_res1", res_log.size() > 1 ? 32'(res_log[1]) : 32'hFFFF, 32'd2);
        chk("kill_cmd1", cmd_log.size() > 1 ? 32'(cmd_log[1]) : 32'hFFFF, 32'd2);

        // full queue
        for (int k = 0; k < 4; k++) begin
            issue_valid = 1; issue_instr = mkins(7'h00, 3'd1, 5'd0); issue_id = 3'(4 + k);
            tick();
        end
        issue_id = 3'd0;
        @(negedge clk);
        chk("full_ready", 32'(issue_ready), 32'd0);
        chk("full_accept", 32'(issue_accept), 32'd1);
        tick();
        issue_instr = 32'h00200093;
        @(negedge clk);
        chk("full_rej_ready", 32'(issue_ready), 32'd1);
        chk("full_rej_accept", 32'(issue_accept), 32'd0);
        tick();
        issue_valid = 0;
        for (int k = 0; k < 4; k++) begin
            commit_valid = 1; commit_id = 3'(4 + k);
            tick();
        end
        commit_valid = 0;
        repeat (20) tick();

        // reset while waiting for the backend
        issue_valid = 1; issue_instr = mkins(7'h00, 3'd4, 5'd7); issue_id = 3'd6;
        tick();
        issue_valid = 0; commit_valid = 1; commit_id = 3'd6;
        tick();
        commit_valid = 0;
        found = 0;
        for (int k = 0; k < 10 && !found; k++) begin
            @(negedge clk);
            if (rsp_ready) found = 1; else tick();
        end
        chk("rmf_in_rsp", 32'(found), 32'd1);
        tick();
        rst = 1;
        tick();
        rst = 0;
        @(negedge clk);
        chk("rmf_cmd_valid", 32'(cmd_valid), 32'd0);
        chk("rmf_rsp_ready", 32'(rsp_ready), 32'd0);
        chk("rmf_res_valid", 32'(result_valid), 32'd0);
        chk("rmf_cmd_funct", 32'(cmd_funct), 32'd0);
        chk("rmf_cmd_rs1", cmd_rs1, 32'd0);
        chk("rmf_res_data", result_data, 32'd0);
        chk("rmf_res_rd", 32'(result_rd), 32'd0);
        chk("rmf_issue_ready", 32'(issue_ready), 32'd1);
        tick();
        rsp_valid = 1; rsp_data = 32'h1234;
        tick();
        rsp_valid = 0;
        seen = 0;
        repeat (6) begin
            @(negedge clk);
            if (result_valid) seen++;
            tick();
        end
        chk("rmf_no_result", 32'(seen), 32'd0);

        // random traffic
        res_cnt = 0;
        for (int c = 0; c < 3000; c++) begin
            f7  = 7'($urandom);
            f3r = 3'($urandom_range(0, 7));
            rdr = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom);
            issue_valid    = ($urandom_range(0, 9) < 6);
            issue_instr    = {f7, 10'($urandom), f3r, rdr, ($urandom_range(0, 3) == 0) ? 7'h13 : 7'h0B};
            issue_id       = 3'($urandom_range(0, 7));
            issue_rs1      = $urandom;
            issue_rs2      = $urandom;
            issue_rs_valid = ($urandom_range(0, 4) == 0) ? 2'($urandom) : 2'b11;
            commit_valid   = ($urandom_range(0, 9) < 3);
            if (mq.size() > 0 && $urandom_range(0, 3) != 0)
                commit_id = mq[$urandom_range(0, mq.size() - 1)].id;
            else
                commit_id = 3'($urandom_range(0, 7));
            commit_kill  = ($urandom_range(0, 99) < 15);
            cmd_ready    = ($urandom_range(0, 9) < 6);
            result_ready = ($urandom_range(0, 9) < 6);
            rsp_valid    = ($urandom_range(0, 9) < 4);
            rsp_data     = $urandom;
            tick();
        end
        idle_in();
        cmd_ready = 1; result_ready = 1; rsp_valid = 1; rsp_data = 32'hCAFE0001;
        for (int c = 0; c < 200; c++) begin
            commit_valid = 1; commit_id = 3'(c % 8);
            tick();
        end
        idle_in();
        repeat (4) tick();
        @(negedge clk);
        chk("rand_activity", 32'(res_cnt > 50), 32'd1);
        chk("drain_cmd_idle", 32'(cmd_valid), 32'd0);
        chk("drain_res_idle", 32'(result_valid), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
